// File: rtl/ami_pkg.sv
// Shared types for the ami_wmux AXI write multiplexer.
// Response/burst encodings, order-FIFO entry and W-stage states.
package ami_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam int ORD_CHW = 2;
  localparam int ORD_LW  = 8;

  typedef struct packed {
    logic [ORD_CHW-1:0] ch;
    logic [ORD_LW-1:0]  len;
  } ord_t;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } wst_t;

endpackage

// File: rtl/ami_wmux_sfifo.sv
// Small show-ahead synchronous FIFO (depth 2**AW).
// Holds issued-AW order entries for the W stage.
module sfifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          we,
  input  logic          re,
  output logic          full,
  output logic          empty,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_we;
  logic          w_re;

  assign full  = (r_cnt == (AW+1)'(2**AW));
  assign empty = (r_cnt == '0);
  assign w_we  = we && !full;
  assign w_re  = re && !empty;
  assign q     = r_mem[r_rp];

  always_ff @(posedge ACLK) begin
    if (w_we) r_mem[r_wp] <= d;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_we) r_wp <= r_wp + 1'b1;
      if (w_re) r_rp <= r_rp + 1'b1;
      unique case ({w_we, w_re})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ami_wmux.sv
// Round-robin N_CH user write ports onto one AXI AW/W/B master.
// Optional sticky per-channel error flags: AMI_ERR_STATUS_EN.
module ami_wmux
  import ami_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AMI_OD = 4,
  localparam int CHW    = $clog2(N_CH),
  localparam int UIW    = AXI_IW - CHW,
  localparam int WSTRBW = AXI_DW / 8
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  output logic [AXI_IW-1:0]            AWID,
  output logic [AXI_AW-1:0]            AWADDR,
  output logic [AXI_LW-1:0]            AWLEN,
  output logic [2:0]                   AWSIZE,
  output logic [1:0]                   AWBURST,
  output logic                         AWVALID,
  input  logic                         AWREADY,
  output logic [AXI_DW-1:0]            WDATA,
  output logic [WSTRBW-1:0]            WSTRB,
  output logic                         WLAST,
  output logic                         WVALID,
  input  logic                         WREADY,
  input  logic [AXI_IW-1:0]            BID,
  input  logic [1:0]                   BRESP,
  input  logic                         BVALID,
  output logic                         BREADY,
  input  logic [N_CH-1:0][UIW-1:0]     usr_awid,
  input  logic [N_CH-1:0][AXI_AW-1:0]  usr_awaddr,
  input  logic [N_CH-1:0][AXI_LW-1:0]  usr_awlen,
  input  logic [N_CH-1:0][2:0]         usr_awsize,
  input  logic [N_CH-1:0][1:0]         usr_awburst,
  input  logic [N_CH-1:0]              usr_awvalid,
  output logic [N_CH-1:0]              usr_awready,
  input  logic [N_CH-1:0][AXI_DW-1:0]  usr_wdata,
  input  logic [N_CH-1:0][WSTRBW-1:0]  usr_wstrb,
  input  logic [N_CH-1:0]              usr_wvalid,
  output logic [N_CH-1:0]              usr_wready,
  output logic [N_CH-1:0][UIW-1:0]     usr_bid,
  output logic [N_CH-1:0][1:0]         usr_bresp,
  output logic [N_CH-1:0]              usr_bvalid,
  input  logic [N_CH-1:0]              usr_bready
`ifdef AMI_ERR_STATUS_EN
  ,
  output logic [N_CH-1:0]              usr_err
`endif
);

  localparam int OUT_AW = $clog2(AMI_OD + 1);
  localparam int OAW    = $clog2(AMI_OD);
  localparam int ODW    = CHW + AXI_LW;

  logic              r_aw_full;
  logic [AXI_IW-1:0] r_awid;
  logic [AXI_AW-1:0] r_awaddr;
  logic [AXI_LW-1:0] r_awlen;
  logic [2:0]        r_awsize;
  logic [1:0]        r_awburst;
  logic [CHW-1:0]    r_rr;
  logic [OUT_AW-1:0] r_ost;

  logic              w_found;
  logic [CHW-1:0]    w_win;
  logic              w_room;
  logic              w_grant;
  logic              w_aw_hs;
  logic              w_b_hs;
  logic              w_ord_full;
  logic              w_ord_empty;
  logic              w_pop;
  logic [ODW-1:0]    w_ord_q;

  wst_t              r_wst;
  wst_t              w_wst_nxt;
  logic [CHW-1:0]    r_w_ch;
  logic [AXI_LW-1:0] r_w_len;
  logic [AXI_LW-1:0] r_beat;
  logic              w_burst;
  logic              w_w_hs;
  logic              w_last_hs;

  logic [CHW-1:0]    w_bch;
  logic              w_bok;

  assign AWID    = r_awid;
  assign AWADDR  = r_awaddr;
  assign AWLEN   = r_awlen;
  assign AWSIZE  = r_awsize;
  assign AWBURST = r_awburst;
  assign AWVALID = r_aw_full;

  always_comb begin : p_arb
    int v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      v_idx = (int'(r_rr) + i) % N_CH;
      if (!w_found && usr_awvalid[CHW'(v_idx)]) begin
        w_found = 1'b1;
        w_win   = CHW'(v_idx);
      end
    end
  end

  // Slot in the AW register counts as outstanding before it handshakes.
  assign w_room = ({1'b0, r_ost} + (OUT_AW+1)'(r_aw_full))
                < (OUT_AW+1)'(AMI_OD);
  assign w_grant = (!r_aw_full || AWREADY) && w_room
                && !w_ord_full && w_found;
  assign usr_awready = w_grant ? (N_CH'(1) << w_win) : '0;
  assign w_aw_hs = r_aw_full && AWREADY;
  assign w_b_hs  = BVALID && BREADY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_full <= 1'b0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_rr      <= '0;
    end else if (w_grant) begin
      r_aw_full <= 1'b1;
      r_awid    <= {w_win, usr_awid[w_win]};
      r_awaddr  <= usr_awaddr[w_win];
      r_awlen   <= usr_awlen[w_win];
      r_awsize  <= usr_awsize[w_win];
      r_awburst <= usr_awburst[w_win];
      r_rr      <= (w_win == CHW'(N_CH - 1)) ? '0 : w_win + 1'b1;
    end else if (AWREADY) begin
      r_aw_full <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_ost <= '0;
    end else begin
      unique case ({w_aw_hs, w_b_hs})
        2'b10:   r_ost <= r_ost + 1'b1;
        2'b01:   r_ost <= r_ost - 1'b1;
        default: r_ost <= r_ost;
      endcase
    end
  end

  sfifo #(
    .DW (ODW),
    .AW (OAW)
  ) u_ord (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .we      (w_aw_hs),
    .re      (w_pop),
    .full    (w_ord_full),
    .empty   (w_ord_empty),
    .d       ({r_awid[AXI_IW-1 -: CHW], r_awlen}),
    .q       (w_ord_q)
  );

  always_comb begin
    w_wst_nxt  = r_wst;
    w_pop      = 1'b0;
    w_burst    = (r_wst == W_BURST);
    WVALID     = w_burst && usr_wvalid[r_w_ch];
    WLAST      = w_burst && (r_beat == r_w_len);
    WDATA      = usr_wdata[r_w_ch];
    WSTRB      = usr_wstrb[r_w_ch];
    usr_wready = '0;
    if (w_burst) usr_wready[r_w_ch] = WREADY;
    w_w_hs     = WVALID && WREADY;
    w_last_hs  = w_w_hs && WLAST;
    unique case (r_wst)
      W_IDLE: begin
        if (!w_ord_empty) begin
          w_pop     = 1'b1;
          w_wst_nxt = W_BURST;
        end
      end
      W_BURST: begin
        if (w_last_hs) begin
          if (!w_ord_empty) w_pop = 1'b1;
          else w_wst_nxt = W_IDLE;
        end
      end
      default: w_wst_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wst   <= W_IDLE;
      r_w_ch  <= '0;
      r_w_len <= '0;
      r_beat  <= '0;
    end else begin
      r_wst <= w_wst_nxt;
      if (w_pop) begin
        {r_w_ch, r_w_len} <= w_ord_q;
        r_beat <= '0;
      end else if (w_w_hs) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // IDs naming a non-existent channel are acknowledged and dropped.
  assign w_bch = BID[AXI_IW-1 -: CHW];
  assign w_bok = ({1'b0, w_bch} < (CHW+1)'(N_CH));

  always_comb begin
    usr_bvalid = '0;
    BREADY     = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      usr_bid[i]   = BID[UIW-1:0];
      usr_bresp[i] = BRESP;
    end
    if (w_bok) begin
      usr_bvalid[w_bch] = BVALID;
      BREADY            = usr_bready[w_bch];
    end
  end

`ifdef AMI_ERR_STATUS_EN
  logic [N_CH-1:0] r_err;

  assign usr_err = r_err;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_err <= '0;
    end else if (w_b_hs && w_bok && (BRESP != OKAY)) begin
      r_err[w_bch] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ami_wmux.sv
// Directed scoreboard bench for ami_wmux.
// Covers RR order, outstanding limit, AW stall, back-to-back W, B routing.
module tb_ami_wmux;
  import ami_pkg::*;

  localparam int N_CH = 4;
  localparam int DW   = 128;
  localparam int AW   = 32;
  localparam int IW   = 8;
  localparam int LW   = 8;
  localparam int OD   = 4;
  localparam int SW   = DW / 8;
  localparam int CHW  = 2;
  localparam int UIW  = IW - CHW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [IW-1:0]  AWID;
  logic [AW-1:0]  AWADDR;
  logic [LW-1:0]  AWLEN;
  logic [2:0]     AWSIZE;
  logic [1:0]     AWBURST;
  logic           AWVALID;
  logic           AWREADY;
  logic [DW-1:0]  WDATA;
  logic [SW-1:0]  WSTRB;
  logic           WLAST;
  logic           WVALID;
  logic           WREADY;
  logic [IW-1:0]  BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;

  logic [N_CH-1:0][UIW-1:0] usr_awid    = '0;
  logic [N_CH-1:0][AW-1:0]  usr_awaddr  = '0;
  logic [N_CH-1:0][LW-1:0]  usr_awlen   = '0;
  logic [N_CH-1:0][2:0]     usr_awsize  = '0;
  logic [N_CH-1:0][1:0]     usr_awburst = '0;
  logic [N_CH-1:0]          usr_awvalid = '0;
  logic [N_CH-1:0]          usr_awready;
  logic [N_CH-1:0][DW-1:0]  usr_wdata;
  logic [N_CH-1:0][SW-1:0]  usr_wstrb;
  logic [N_CH-1:0]          usr_wvalid;
  logic [N_CH-1:0]          usr_wready;
  logic [N_CH-1:0][UIW-1:0] usr_bid;
  logic [N_CH-1:0][1:0]     usr_bresp;
  logic [N_CH-1:0]          usr_bvalid;
  logic [N_CH-1:0]          usr_bready;
`ifdef AMI_ERR_STATUS_EN
  logic [N_CH-1:0]          usr_err;
`endif

  ami_wmux #(
    .N_CH   (N_CH),
    .AXI_DW (DW),
    .AXI_AW (AW),
    .AXI_IW (IW),
    .AXI_LW (LW),
    .AMI_OD (OD)
  ) dut (
    .ACLK        (clk),
    .ARESETn     (rst_n),
    .AWID        (AWID),
    .AWADDR      (AWADDR),
    .AWLEN       (AWLEN),
    .AWSIZE      (AWSIZE),
    .AWBURST     (AWBURST),
    .AWVALID     (AWVALID),
    .AWREADY     (AWREADY),
    .WDATA       (WDATA),
    .WSTRB       (WSTRB),
    .WLAST       (WLAST),
    .WVALID      (WVALID),
    .WREADY      (WREADY),
    .BID         (BID),
    .BRESP       (BRESP),
    .BVALID      (BVALID),
    .BREADY      (BREADY),
    .usr_awid    (usr_awid),
    .usr_awaddr  (usr_awaddr),
    .usr_awlen   (usr_awlen),
    .usr_awsize  (usr_awsize),
    .usr_awburst (usr_awburst),
    .usr_awvalid (usr_awvalid),
    .usr_awready (usr_awready),
    .usr_wdata   (usr_wdata),
    .usr_wstrb   (usr_wstrb),
    .usr_wvalid  (usr_wvalid),
    .usr_wready  (usr_wready),
    .usr_bid     (usr_bid),
    .usr_bresp   (usr_bresp),
    .usr_bvalid  (usr_bvalid),
    .usr_bready  (usr_bready)
`ifdef AMI_ERR_STATUS_EN
    ,
    .usr_err     (usr_err)
`endif
  );

  typedef struct {
    logic [UIW-1:0] uid;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  len;
  } req_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } eaw_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } ew_t;

  req_t        req_q [N_CH][$];
  eaw_t        exp_aw[$];
  ew_t         exp_w[$];
  int unsigned wcnt  [N_CH] = '{default: 0};
  int unsigned nbeat [N_CH] = '{default: 0};
  int          n_cmp = 0;
  int          n_bad = 0;
  int          aw_cnt = 0;

  function automatic logic [DW-1:0] wdat(int c, int unsigned k);
    return {64'hC0DE_0000_0000_0000, 32'(c), 32'(k)};
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_src
    assign usr_wdata[g] = wdat(g, wcnt[g]);
    assign usr_wstrb[g] = SW'(1) << g;
  end

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int c, input logic [UIW-1:0] uid,
                     input logic [LW-1:0] len,
                     input logic [AW-1:0] addr);
    req_t r;
    eaw_t e;
    ew_t  w;
    r.uid = uid; r.addr = addr; r.len = len;
    req_q[c].push_back(r);
    e.id = {CHW'(c), uid}; e.addr = addr; e.len = len;
    exp_aw.push_back(e);
    for (int k = 0; k <= int'(len); k++) begin
      w.data = wdat(c, nbeat[c]);
      w.strb = SW'(1) << c;
      w.last = (k == int'(len));
      exp_w.push_back(w);
      nbeat[c]++;
    end
  endtask

  // AXI-side scoreboard plus user-side AW/W source.
  always begin : mon
    bit awh [N_CH];
    bit wh  [N_CH];
    eaw_t e;
    ew_t  w;
    @(negedge clk);
    for (int c = 0; c < N_CH; c++) begin
      awh[c] = usr_awvalid[c] && usr_awready[c];
      wh[c]  = usr_wvalid[c] && usr_wready[c];
    end
    if (rst_n === 1'b1 && AWVALID && AWREADY) begin
      aw_cnt++;
      if (exp_aw.size() == 0) begin
        chk("aw_unexpected", DW'(AWVALID), DW'(0));
      end else begin
        e = exp_aw.pop_front();
        chk("awid", DW'(AWID), DW'(e.id));
        chk("awaddr", DW'(AWADDR), DW'(e.addr));
        chk("awlen", DW'(AWLEN), DW'(e.len));
        chk("awsize", DW'(AWSIZE), DW'(3'd4));
        chk("awburst", DW'(AWBURST), DW'(INCR));
      end
    end
    if (rst_n === 1'b1 && WVALID && WREADY) begin
      if (exp_w.size() == 0) begin
        chk("w_unexpected", DW'(WVALID), DW'(0));
      end else begin
        w = exp_w.pop_front();
        chk("wdata", WDATA, w.data);
        chk("wstrb", DW'(WSTRB), DW'(w.strb));
        chk("wlast", DW'(WLAST), DW'(w.last));
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < N_CH; c++) begin
      if (awh[c] && req_q[c].size() > 0) void'(req_q[c].pop_front());
      if (wh[c]) wcnt[c]++;
      if (req_q[c].size() > 0) begin
        usr_awvalid[c] = 1'b1;
        usr_awid[c]    = req_q[c][0].uid;
        usr_awaddr[c]  = req_q[c][0].addr;
        usr_awlen[c]   = req_q[c][0].len;
        usr_awsize[c]  = 3'd4;
        usr_awburst[c] = INCR;
      end else begin
        usr_awvalid[c] = 1'b0;
      end
    end
  end

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((exp_aw.size() != 0 || exp_w.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", DW'(exp_aw.size() + exp_w.size()), DW'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input int c, input logic [UIW-1:0] uid,
                        input logic [1:0] rsp);
    @(posedge clk);
    #1;
    BVALID = 1'b1;
    BID    = {CHW'(c), uid};
    BRESP  = rsp;
    @(negedge clk);
    chk("b_valid", DW'(usr_bvalid), DW'(N_CH'(1) << c));
    chk("b_id", DW'(usr_bid[c]), DW'(uid));
    chk("b_resp", DW'(usr_bresp[c]), DW'(rsp));
    chk("b_ready", DW'(BREADY), DW'(1));
    @(posedge clk);
    #1;
    BVALID = 1'b0;
  endtask

  initial begin : stim
    int base;
    int n;
    int t1;
    int t2;
    rst_n      = 1'b0;
    AWREADY    = 1'b1;
    WREADY     = 1'b1;
    BVALID     = 1'b0;
    BID        = '0;
    BRESP      = '0;
    usr_bready = '1;
    usr_wvalid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awvalid", DW'(AWVALID), DW'(0));
    chk("rst_wvalid", DW'(WVALID), DW'(0));
    chk("rst_wlast", DW'(WLAST), DW'(0));
    chk("rst_wready", DW'(usr_wready), DW'(0));
    chk("rst_bvalid", DW'(usr_bvalid), DW'(0));
`ifdef AMI_ERR_STATUS_EN
    chk("rst_err", DW'(usr_err), DW'(0));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // all four channels at once: grant order 0,1,2,3
    req(0, 6'h10, 8'd0, 32'h0000_0100);
    req(1, 6'h11, 8'd0, 32'h1000_0100);
    req(2, 6'h12, 8'd0, 32'h2000_0100);
    req(3, 6'h13, 8'd0, 32'h3000_0100);
    drain(60);
    send_b(0, 6'h10, OKAY);
    send_b(1, 6'h11, OKAY);
    send_b(2, 6'h12, OKAY);
    send_b(3, 6'h13, OKAY);

    // pointer wrapped to 0: ch0 beats ch3
    req(0, 6'h20, 8'd0, 32'h0000_0200);
    req(3, 6'h23, 8'd0, 32'h3000_0200);
    drain(40);
    send_b(0, 6'h20, OKAY);
    send_b(3, 6'h23, OKAY);

    // single 4-beat burst, B gated by usr_bready
    req(0, 6'h15, 8'd3, 32'h0000_0300);
    drain(40);
    @(posedge clk);
    #1;
    usr_bready = 4'b1110;
    BVALID = 1'b1;
    BID    = {2'd0, 6'h15};
    BRESP  = OKAY;
    @(negedge clk);
    chk("b_gate_valid", DW'(usr_bvalid), DW'(4'b0001));
    chk("b_gate_ready", DW'(BREADY), DW'(0));
    @(posedge clk);
    #1;
    usr_bready = '1;
    @(negedge clk);
    chk("b_ungate_ready", DW'(BREADY), DW'(1));
    chk("b_ungate_id", DW'(usr_bid[0]), DW'(6'h15));
    @(posedge clk);
    #1;
    BVALID = 1'b0;

    // outstanding limit with no B returned
    base = aw_cnt;
    for (int k = 0; k < 6; k++)
      req(1, 6'(6'h30 + k), 8'd0, 32'h1000_0400 + 32'(k * 16));
    repeat (20) @(posedge clk);
    #1;
    chk("ost_cap", DW'(aw_cnt - base), DW'(OD));
    BVALID = 1'b1;
    BID    = {2'd1, 6'h30};
    BRESP  = OKAY;
    @(negedge clk);
    chk("ost_hold", DW'(usr_awready[1]), DW'(0));
    @(posedge clk);
    #1;
    BVALID = 1'b0;
    @(negedge clk);
    chk("ost_release", DW'(usr_awready[1]), DW'(1));
    repeat (5) @(posedge clk);
    #1;
    chk("ost_fifth", DW'(aw_cnt - base), DW'(5));
    send_b(1, 6'h31, OKAY);
    drain(40);
    for (int k = 2; k < 6; k++) send_b(1, 6'(6'h30 + k), OKAY);

    // AWREADY stall: payload stable, no W ahead of AW
    AWREADY = 1'b0;
    req(2, 6'h22, 8'd1, 32'h2000_0500);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!AWVALID && n < 10);
    chk("stall_awvalid_seen", DW'(AWVALID), DW'(1));
    for (int k = 0; k < 5; k++) begin
      chk("stall_awvalid", DW'(AWVALID), DW'(1));
      chk("stall_awaddr", DW'(AWADDR), DW'(32'h2000_0500));
      chk("stall_awid", DW'(AWID), DW'({2'd2, 6'h22}));
      chk("stall_wvalid", DW'(WVALID), DW'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    AWREADY = 1'b1;
    drain(40);
    send_b(2, 6'h22, OKAY);

    // back-to-back bursts ch1 then ch2
    WREADY = 1'b0;
    req(1, 6'h01, 8'd1, 32'h1000_0600);
    req(2, 6'h02, 8'd1, 32'h2000_0600);
    repeat (6) @(posedge clk);
    #1;
    WREADY = 1'b1;
    t1 = -100;
    t2 = -100;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (WVALID && WREADY) begin
        if (usr_wready[1] && WLAST) t1 = k;
        if (usr_wready[2] && t2 < 0) t2 = k;
      end
    end
    chk("b2b_no_bubble", DW'(t2 - t1), DW'(1));
    @(posedge clk);
    #1;
    drain(20);
    send_b(1, 6'h01, OKAY);
    send_b(2, 6'h02, OKAY);

    // error response on ch3
    req(3, 6'h33, 8'd0, 32'h3000_0700);
    drain(40);
    send_b(3, 6'h33, SLVERR);
`ifdef AMI_ERR_STATUS_EN
    @(negedge clk);
    chk("err_set", DW'(usr_err), DW'(4'b1000));
    repeat (3) @(negedge clk);
    chk("err_sticky", DW'(usr_err), DW'(4'b1000));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_awvalid", DW'(AWVALID), DW'(0));
    chk("rst2_wvalid", DW'(WVALID), DW'(0));
`ifdef AMI_ERR_STATUS_EN
    chk("err_cleared", DW'(usr_err), DW'(0));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
